bitonic_sort_scheduler: RTL and testbench

Frame sequencer that sits in front of a 2**LOG_INPUT_NUM-input bitonic sorting network. It collects a serial valid/ready element stream into one frame and tags each element with its arrival index as the label. It issues the frame to the sorter with a single x_valid pulse, captures the sorted result on y_valid, and replays it serially. Short frames, closed early by s_last, are padded so that pad slots sort to the tail and are never emitted.

---
 rtl/bitonic_sort_scheduler_pkg.sv | 33 +++
 rtl/bitonic_sort_scheduler_frame_buffer.sv | 72 +++++++
 rtl/bitonic_sort_scheduler.sv | 154 +++++++++++++++
 tb/tb_bitonic_sort_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitonic_sort_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitonic_sched_pkg                                                    |
// | FSM state encoding, pad-value and slot-packing helpers               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bitonic_sched_pkg;

    localparam logic [1:0] c_state_fill  = 2'd0;
    localparam logic [1:0] c_state_issue = 2'd1;
    localparam logic [1:0] c_state_wait  = 2'd2;
    localparam logic [1:0] c_state_drain = 2'd3;

    // Value that sorts to the tail under the sorter's ordering; callers slice to width.
    function automatic logic [63:0] pad_value(input int width, input bit is_signed,
                                              input bit ascending);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < 64; b++) begin
            v[b] = (b < width) ? ascending : 1'b0;
        end
        if (is_signed && width > 0) begin
            v[width-1] = ~v[width-1];
        end
        return v;
    endfunction

    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitonic_sort_scheduler_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitonic_frame_buffer                                                 |
// | N-slot data+label register file shared by the input and result frame |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bitonic_frame_buffer
    import bitonic_sched_pkg::*;
#(
    parameter int SLOT_IDX_WIDTH = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int LABEL_WIDTH    = 4,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_wr_en,
    input  logic [SLOT_IDX_WIDTH-1:0]                     i_wr_idx,
    input  logic [DATA_WIDTH-1:0]                         i_wr_data,
    input  logic [LABEL_WIDTH-1:0]                        i_wr_label,
    input  logic                                          i_load_en,
    input  logic [DATA_WIDTH*(2**SLOT_IDX_WIDTH)-1:0]     i_load_data,
    input  logic [LABEL_WIDTH*(2**SLOT_IDX_WIDTH)-1:0]    i_load_label,
    input  logic                                          i_pad_clr,
    output logic [DATA_WIDTH*(2**SLOT_IDX_WIDTH)-1:0]     o_frame_data,
    output logic [LABEL_WIDTH*(2**SLOT_IDX_WIDTH)-1:0]    o_frame_label,
    input  logic [SLOT_IDX_WIDTH-1:0]                     i_rd_idx,
    output logic [DATA_WIDTH-1:0]                         o_rd_data,
    output logic [LABEL_WIDTH-1:0]                        o_rd_label
);

    localparam int c_n_slots = 2 ** SLOT_IDX_WIDTH;

    logic [DATA_WIDTH-1:0]  w_data  [c_n_slots];
    logic [LABEL_WIDTH-1:0] w_label [c_n_slots];

    generate
        for (genvar g = 0; g < c_n_slots; g++) begin : g_slot
            localparam logic [LABEL_WIDTH-1:0] c_slot_label = LABEL_WIDTH'(g);

            logic [DATA_WIDTH-1:0]  r_data;
            logic [LABEL_WIDTH-1:0] r_label;

            // Re-padding wins over everything so a closed frame never leaks into the next.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_data  <= PAD_VALUE;
                    r_label <= '0;
                end else if (i_pad_clr) begin
                    r_data  <= PAD_VALUE;
                    r_label <= c_slot_label;
                end else if (i_load_en) begin
                    r_data  <= i_load_data[slot_lsb(g, DATA_WIDTH) +: DATA_WIDTH];
                    r_label <= i_load_label[slot_lsb(g, LABEL_WIDTH) +: LABEL_WIDTH];
                end else if (i_wr_en && (i_wr_idx == SLOT_IDX_WIDTH'(g))) begin
                    r_data  <= i_wr_data;
                    r_label <= i_wr_label;
                end
            end

            assign w_data[g]  = r_data;
            assign w_label[g] = r_label;
            assign o_frame_data[slot_lsb(g, DATA_WIDTH) +: DATA_WIDTH]    = r_data;
            assign o_frame_label[slot_lsb(g, LABEL_WIDTH) +: LABEL_WIDTH] = r_label;
        end
    endgenerate

    assign o_rd_data  = w_data[i_rd_idx];
    assign o_rd_label = w_label[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/bitonic_sort_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitonic_sort_scheduler                                               |
// | Collects a stream into a frame, issues it to a sorter, replays result|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bitonic_sort_scheduler
    import bitonic_sched_pkg::*;
#(
    parameter int LOG_INPUT_NUM = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int LABEL_WIDTH   = LOG_INPUT_NUM,
    parameter int SIGNED        = 0,
    parameter int ASCENDING     = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    input  logic [DATA_WIDTH-1:0]                      s_data,
    input  logic                                       s_last,
    output logic                                       srt_x_valid,
    output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]   srt_x,
    output logic [LABEL_WIDTH*(2**LOG_INPUT_NUM)-1:0]  srt_x_label,
    input  logic                                       srt_y_valid,
    input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]   srt_y,
    input  logic [LABEL_WIDTH*(2**LOG_INPUT_NUM)-1:0]  srt_y_label,
    output logic                                       m_valid,
    input  logic                                       m_ready,
    output logic [DATA_WIDTH-1:0]                      m_data,
    output logic [LABEL_WIDTH-1:0]                     m_label,
    output logic                                       m_last,
    output logic                                       busy
);

    localparam int c_n_slots = 2 ** LOG_INPUT_NUM;
    localparam logic [63:0] c_pad_wide = pad_value(DATA_WIDTH, SIGNED != 0, ASCENDING != 0);
    localparam logic [DATA_WIDTH-1:0] c_pad = c_pad_wide[DATA_WIDTH-1:0];
    localparam logic [LOG_INPUT_NUM:0] c_one       = (LOG_INPUT_NUM+1)'(1);
    localparam logic [LOG_INPUT_NUM:0] c_last_slot = (LOG_INPUT_NUM+1)'(c_n_slots - 1);

    logic [1:0]             r_state;
    logic [LOG_INPUT_NUM:0] r_count;
    logic [LOG_INPUT_NUM:0] r_nreal;
    logic [LOG_INPUT_NUM:0] r_idx;
    logic                   r_s_ready;
    logic                   r_x_valid;
    logic                   r_m_valid;
    logic                   r_m_last;
    logic                   r_busy;

    logic                   w_in_beat;
    logic                   w_close;
    logic                   w_capture;
    logic                   w_out_beat;
    logic                   w_done;
    logic [LOG_INPUT_NUM:0] w_idx_inc;

    // r_s_ready is only high in FILL, so it doubles as the state qualifier for input beats.
    assign w_in_beat  = s_valid & r_s_ready;
    assign w_close    = w_in_beat & (s_last | (r_count == c_last_slot));
    assign w_capture  = (r_state == c_state_wait) & srt_y_valid;
    assign w_out_beat = r_m_valid & m_ready;
    assign w_done     = w_out_beat & r_m_last;
    assign w_idx_inc  = r_idx + c_one;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_state_fill;
            r_count   <= '0;
            r_nreal   <= '0;
            r_idx     <= '0;
            r_s_ready <= 1'b1;
            r_x_valid <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                c_state_fill: begin
                    if (w_in_beat) begin
                        r_count <= r_count + c_one;
                        if (w_close) begin
                            r_nreal   <= r_count + c_one;
                            r_state   <= c_state_issue;
                            r_s_ready <= 1'b0;
                            r_x_valid <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                c_state_issue: begin
                    r_x_valid <= 1'b0;
                    r_state   <= c_state_wait;
                end
                c_state_wait: begin
                    if (srt_y_valid) begin
                        r_idx     <= '0;
                        r_m_valid <= 1'b1;
                        r_m_last  <= (r_nreal == c_one);
                        r_state   <= c_state_drain;
                    end
                end
                c_state_drain: begin
                    if (w_out_beat) begin
                        if (r_m_last) begin
                            r_state   <= c_state_fill;
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                            r_count   <= '0;
                            r_s_ready <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_idx    <= w_idx_inc;
                            r_m_last <= (w_idx_inc == (r_nreal - c_one));
                        end
                    end
                end
                default: r_state <= c_state_fill;
            endcase
        end
    end

    bitonic_frame_buffer #(
        .SLOT_IDX_WIDTH (LOG_INPUT_NUM),
        .DATA_WIDTH     (DATA_WIDTH),
        .LABEL_WIDTH    (LABEL_WIDTH),
        .PAD_VALUE      (c_pad)
    ) u_frame_buffer (
        .clk           (clk),
        .rst           (rst),
        .i_wr_en       (w_in_beat),
        .i_wr_idx      (r_count[LOG_INPUT_NUM-1:0]),
        .i_wr_data     (s_data),
        .i_wr_label    (LABEL_WIDTH'(r_count)),
        .i_load_en     (w_capture),
        .i_load_data   (srt_y),
        .i_load_label  (srt_y_label),
        .i_pad_clr     (w_done),
        .o_frame_data  (srt_x),
        .o_frame_label (srt_x_label),
        .i_rd_idx      (r_idx[LOG_INPUT_NUM-1:0]),
        .o_rd_data     (m_data),
        .o_rd_label    (m_label)
    );

    assign s_ready     = r_s_ready;
    assign srt_x_valid = r_x_valid;
    assign m_valid     = r_m_valid;
    assign m_last      = r_m_last;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bitonic_sort_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bitonic_sort_scheduler                                            |
// | Two schedulers (unsigned-asc, signed-desc) around a latency-3 sorter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bitonic_sort_scheduler;

    localparam int LOG = 2;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int LW  = 2;
    localparam int LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic          s_valid [2];
    logic          s_ready [2];
    logic [DW-1:0] s_data  [2];
    logic          s_last  [2];
    logic          srt_x_valid [2];
    logic [DW*N-1:0] srt_x [2];
    logic [LW*N-1:0] srt_x_label [2];
    logic          srt_y_valid [2];
    logic [DW*N-1:0] srt_y [2];
    logic [LW*N-1:0] srt_y_label [2];
    logic          m_valid [2];
    logic          m_ready [2];
    logic [DW-1:0] m_data  [2];
    logic [LW-1:0] m_label [2];
    logic          m_last  [2];
    logic          busy    [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            bitonic_sort_scheduler #(
                .LOG_INPUT_NUM (LOG),
                .DATA_WIDTH    (DW),
                .LABEL_WIDTH   (LW),
                .SIGNED        (g),
                .ASCENDING     (1 - g)
            ) u_dut (
                .clk         (clk),
                .rst         (rst_n),
                .s_valid     (s_valid[g]),
                .s_ready     (s_ready[g]),
                .s_data      (s_data[g]),
                .s_last      (s_last[g]),
                .srt_x_valid (srt_x_valid[g]),
                .srt_x       (srt_x[g]),
                .srt_x_label (srt_x_label[g]),
                .srt_y_valid (srt_y_valid[g]),
                .srt_y       (srt_y[g]),
                .srt_y_label (srt_y_label[g]),
                .m_valid     (m_valid[g]),
                .m_ready     (m_ready[g]),
                .m_data      (m_data[g]),
                .m_label     (m_label[g]),
                .m_last      (m_last[g]),
                .busy        (busy[g])
            );
        end
    endgenerate

    // Ordering key: instance 0 is unsigned ascending, instance 1 signed descending.
    function automatic int key(input int u, input logic [7:0] v);
        return (u == 0) ? int'(v) : -int'($signed(v));
    endfunction

    function automatic logic [7:0] pad_of(input int u);
        return (u == 0) ? 8'hFF : 8'h80;
    endfunction

    // Sorter model: stable sort by key, result valid LAT cycles after issue; not cleared by DUT reset.
    int            cnt [2] = '{0, 0};
    logic [DW-1:0] sd [N];
    logic [LW-1:0] sl [N];
    logic [DW*N-1:0] py;
    logic [LW*N-1:0] pl;
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            srt_y_valid[g] <= 1'b0;
            if (cnt[g] > 0) begin
                cnt[g] = cnt[g] - 1;
                if (cnt[g] == 0) srt_y_valid[g] <= 1'b1;
            end
            if (srt_x_valid[g] === 1'b1) begin
                for (int i = 0; i < N; i++) begin
                    sd[i] = srt_x[g][i*DW +: DW];
                    sl[i] = srt_x_label[g][i*LW +: LW];
                end
                for (int i = 1; i < N; i++) begin
                    for (int j = i; j > 0 && key(g, sd[j]) < key(g, sd[j-1]); j--) begin
                        logic [DW-1:0] td;
                        logic [LW-1:0] tl;
                        td = sd[j]; sd[j] = sd[j-1]; sd[j-1] = td;
                        tl = sl[j]; sl[j] = sl[j-1]; sl[j-1] = tl;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    py[i*DW +: DW] = sd[i];
                    pl[i*LW +: LW] = sl[i];
                end
                srt_y[g]       <= py;
                srt_y_label[g] <= pl;
                cnt[g] = LAT;
            end
        end
    end

    logic [7:0] frm [$];
    logic [7:0] exp_d [$];
    int         exp_l [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: stable order of the arrival stream by key; label is arrival index.
    task automatic expect_sorted(input int u, input int n);
        int ord [$];
        int pos;
        ord = {};
        for (int i = 0; i < n; i++) begin
            pos = ord.size();
            for (int p = ord.size() - 1; p >= 0; p--) begin
                if (key(u, frm[ord[p]]) > key(u, frm[i])) pos = p;
            end
            ord.insert(pos, i);
        end
        exp_d = {};
        exp_l = {};
        foreach (ord[k]) begin
            exp_d.push_back(frm[ord[k]]);
            exp_l.push_back(ord[k]);
        end
    endtask

    task automatic send_beats(input int u, input int n, input bit last_on_full);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("s_ready_fill", s_ready[u], 1);
            s_valid[u] = 1'b1;
            s_data[u]  = frm[i];
            s_last[u]  = (i == n - 1) ? ((n < N) ? 1'b1 : last_on_full) : 1'b0;
        end
        @(negedge clk);
        s_valid[u] = 1'b0;
        s_last[u]  = 1'b0;
        check("issue_pulse", srt_x_valid[u], 1);
        check("issue_s_ready", s_ready[u], 0);
        check("issue_busy", busy[u], 1);
        for (int i = 0; i < N; i++) begin
            if (i < n) begin
                check("srt_x_slot", srt_x[u][i*DW +: DW], frm[i]);
                check("srt_x_label", srt_x_label[u][i*LW +: LW], i);
            end else begin
                check("srt_x_pad", srt_x[u][i*DW +: DW], pad_of(u));
            end
        end
        @(negedge clk);
        check("issue_one_cycle", srt_x_valid[u], 0);
        check("wait_m_valid", m_valid[u], 0);
    endtask

    task automatic drain_check(input int u, input int n, input int mode);
        int         k = 0;
        int         stall = 0;
        bit         held = 0;
        bit         rdy;
        logic [7:0] hd;
        logic [1:0] hl;
        logic       hlast;
        for (int cyc = 0; cyc < 60 && k < n; cyc++) begin
            check("drain_s_ready", s_ready[u], 0);
            if (held) begin
                check("hold_valid", m_valid[u], 1);
                check("hold_data", m_data[u], hd);
                check("hold_label", m_label[u], hl);
                check("hold_last", m_last[u], hlast);
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else if (k == 1 && stall < 5) begin rdy = 1'b0; stall++; end
            else rdy = 1'b1;
            m_ready[u] = rdy;
            held = 0;
            if (m_valid[u] === 1'b1) begin
                if (rdy) begin
                    check("m_data", m_data[u], exp_d[k]);
                    check("m_label", m_label[u], exp_l[k]);
                    check("m_last", m_last[u], (k == n - 1));
                    k++;
                end else begin
                    held = 1; hd = m_data[u]; hl = m_label[u]; hlast = m_last[u];
                end
            end
            @(negedge clk);
        end
        m_ready[u] = 1'b0;
        check("drain_count", k, n);
        check("post_m_valid", m_valid[u], 0);
        check("post_s_ready", s_ready[u], 1);
        check("post_busy", busy[u], 0);
    endtask

    task automatic run_frame(input int u, input int n, input bit last_on_full, input int mode);
        expect_sorted(u, n);
        send_beats(u, n, last_on_full);
        drain_check(u, n, mode);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            s_valid[u] = 1'b0; s_data[u] = '0; s_last[u] = 1'b0; m_ready[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_s_ready", s_ready[u], 1);
            check("rst_x_valid", srt_x_valid[u], 0);
            check("rst_m_valid", m_valid[u], 0);
            check("rst_m_last", m_last[u], 0);
            check("rst_busy", busy[u], 0);
            check("rst_pad", srt_x[u], {N{pad_of(u)}});
            check("rst_labels", srt_x_label[u], 0);
        end
        rst_n = 1'b1;

        frm = '{8'd5, 8'd3, 8'd9, 8'd1};
        run_frame(0, 4, 1'b1, 0);
        frm = '{8'd7, 8'd2};
        run_frame(0, 2, 1'b1, 0);
        frm = '{8'hFF, 8'd4};
        run_frame(1, 2, 1'b1, 0);
        frm = '{8'd11, 8'd200, 8'd3, 8'd50};
        run_frame(0, 4, 1'b0, 2);
        frm = '{8'd42};
        run_frame(0, 1, 1'b1, 0);

        // Reset while waiting on the sorter; its late result must be ignored.
        frm = '{8'd8, 8'd6, 8'd7, 8'd5};
        send_beats(0, 4, 1'b1);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("stale_m_valid", m_valid[0], 0);
        end
        check("stale_s_ready", s_ready[0], 1);
        frm = '{8'd4, 8'd3, 8'd2, 8'd1};
        run_frame(0, 4, 1'b1, 1);

        for (int r = 0; r < 10; r++) begin
            int u;
            int n;
            u = (r % 3 == 2) ? 1 : 0;
            n = int'($urandom_range(1, N));
            frm = {};
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
            run_frame(u, n, 1'($urandom_range(0, 1)), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
